// File: rtl/vcve2_vec_ex_seq.sv
// Vector element sequencer: accepts one vector op from ID, walks the VRF word by word,
// feeds packed operands to EX and writes each result word back with tail byte-enables.
//  state   | meaning
//  IDLE    | waiting for an op from ID
//  READ    | VRF read request for the current word
//  WAIT_RD | read granted, waiting for read data
//  EXEC    | operands presented to EX, waiting for ex_valid
//  WRITE   | result write request for the current word
//  DONE    | one-cycle completion pulse
module vcve2_vec_ex_seq #(
  parameter int unsigned VLEN = 128,
  localparam int unsigned WORDS = VLEN / 32,
  localparam int unsigned WIDX = $clog2(WORDS),
  localparam int unsigned VLW = $clog2(VLEN / 8) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 start_ready_o,
  input  logic                 flush_i,
  input  logic [VLW-1:0]       vl_i,
  input  logic [2:0]           vsew_i,
  input  logic [4:0]           vs1_i,
  input  logic [4:0]           vs2_i,
  input  logic [4:0]           vd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 vrf_rd_req_o,
  input  logic                 vrf_rd_gnt_i,
  input  logic                 vrf_rd_rvalid_i,
  input  logic [31:0]          vrf_rdata_a_i,
  input  logic [31:0]          vrf_rdata_b_i,
  input  logic [31:0]          vrf_rdata_c_i,
  output logic [WIDX-1:0]      vrf_word_o,
  output logic [4:0]           vrf_rs1_o,
  output logic [4:0]           vrf_rs2_o,
  output logic [4:0]           vrf_rd_o,
  output logic                 vrf_wr_req_o,
  input  logic                 vrf_wr_gnt_i,
  output logic [31:0]          vrf_wr_data_o,
  output logic [3:0]           vrf_wr_be_o,
  output logic [31:0]          ex_operand_a_o,
  output logic [31:0]          ex_operand_b_o,
  output logic [31:0]          ex_operand_c_o,
  output logic                 ex_vec_instr_o,
  output logic [2:0]           ex_vsew_o,
  output logic                 ex_first_cycle_o,
  input  logic                 ex_valid_i,
  input  logic [31:0]          ex_result_i,
  input  logic [1:0]           imd_val_we_i,
  input  logic [1:0][33:0]     imd_val_d_i,
  output logic [1:0][33:0]     imd_val_q_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT_RD, S_EXEC, S_WRITE, S_DONE
  } state_e;

  localparam logic [VLW+1:0] MAX_BYTES = (VLW + 2)'(VLEN / 8);
  localparam logic [VLW+1:0] ONE_BYTE  = (VLW + 2)'(1);

  state_e            state_q, state_d;
  logic              accept, legal, last_word;
  logic [VLW+1:0]    bytes_raw, bytes_clip, bytes_m1;
  logic [WIDX-1:0]   last_d, last_q, word_q;
  logic [3:0]        tail_d, tail_q;
  logic [2:0]        vsew_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [31:0]       op_a_q, op_b_q, op_c_q, result_q;
  logic              first_q, err_q;
  logic [1:0][33:0]  imd_q;

  assign legal  = ~vsew_i[2] & (vsew_i[1:0] != 2'b11);
  assign accept = start_i & (state_q == S_IDLE);

  // Byte count is clipped to VLEN so an oversized vl can never walk past the register.
  assign bytes_raw  = {2'b00, vl_i} << vsew_i[1:0];
  assign bytes_clip = (bytes_raw > MAX_BYTES) ? MAX_BYTES : bytes_raw;
  assign bytes_m1   = bytes_clip - ONE_BYTE;
  assign last_d     = WIDX'(bytes_m1 >> 2);
  assign tail_d     = (bytes_clip[1:0] == 2'b00) ? 4'hF
                                                 : ((4'b0001 << bytes_clip[1:0]) - 4'b0001);
  assign last_word  = (word_q == last_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    start_ready_o  = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    vrf_rd_req_o   = 1'b0;
    vrf_wr_req_o   = 1'b0;
    vrf_wr_be_o    = 4'h0;
    ex_vec_instr_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (start_i) begin
          if (!legal)            state_d = S_IDLE;
          else if (vl_i == '0)   state_d = S_DONE;
          else                   state_d = S_READ;
        end
      end
      S_READ: begin
        vrf_rd_req_o = 1'b1;
        if (vrf_rd_gnt_i) state_d = S_WAIT_RD;
      end
      S_WAIT_RD: if (vrf_rd_rvalid_i) state_d = S_EXEC;
      S_EXEC: begin
        ex_vec_instr_o = 1'b1;
        if (ex_valid_i) state_d = S_WRITE;
      end
      S_WRITE: begin
        vrf_wr_req_o = 1'b1;
        vrf_wr_be_o  = last_word ? tail_q : 4'hF;
        if (vrf_wr_gnt_i) state_d = last_word ? S_DONE : S_READ;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      vsew_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      last_q   <= '0;
      tail_q   <= '0;
      word_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= '0;
      result_q <= '0;
      imd_q    <= '0;
    end else begin
      err_q   <= accept & ~legal;
      first_q <= (state_q == S_WAIT_RD) & vrf_rd_rvalid_i & ~flush_i;
      if (accept) begin
        vsew_q <= vsew_i;
        rs1_q  <= vs1_i;
        rs2_q  <= vs2_i;
        rd_q   <= vd_i;
        last_q <= last_d;
        tail_q <= tail_d;
        word_q <= '0;
        imd_q  <= '0;
      end
      if ((state_q == S_WAIT_RD) && vrf_rd_rvalid_i && !flush_i) begin
        op_a_q <= vrf_rdata_a_i;
        op_b_q <= vrf_rdata_b_i;
        op_c_q <= vrf_rdata_c_i;
      end
      if ((state_q == S_EXEC) && ex_valid_i && !flush_i) result_q <= ex_result_i;
      if ((state_q == S_WRITE) && vrf_wr_gnt_i && !flush_i && !last_word)
        word_q <= word_q + WIDX'(1);
      // EX may update either intermediate register in any state, including after accept.
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) imd_q[i] <= imd_val_d_i[i];
      end
    end
  end

  assign err_o            = err_q;
  assign ex_first_cycle_o = (state_q == S_EXEC) & first_q;
  assign vrf_word_o       = word_q;
  assign vrf_rs1_o        = rs1_q;
  assign vrf_rs2_o        = rs2_q;
  assign vrf_rd_o         = rd_q;
  assign vrf_wr_data_o    = result_q;
  assign ex_operand_a_o   = op_a_q;
  assign ex_operand_b_o   = op_b_q;
  assign ex_operand_c_o   = op_c_q;
  assign ex_vsew_o        = vsew_q;
  assign imd_val_q_o      = imd_q;

endmodule

// File: tb/tb_vcve2_vec_ex_seq.sv
// Self-checking bench for vcve2_vec_ex_seq: VRF/EX responders with random latencies and a
// word-level reference model of the expected write stream.
module tb_vcve2_vec_ex_seq;
  localparam int VLEN = 128;
  localparam int WIDX = 2;
  localparam int VLW  = 5;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic start_i, start_ready_o, flush_i;
  logic [VLW-1:0] vl_i;
  logic [2:0] vsew_i;
  logic [4:0] vs1_i, vs2_i, vd_i;
  logic busy_o, done_o, err_o;
  logic vrf_rd_req_o, vrf_rd_gnt_i, vrf_rd_rvalid_i;
  logic [31:0] vrf_rdata_a_i, vrf_rdata_b_i, vrf_rdata_c_i;
  logic [WIDX-1:0] vrf_word_o;
  logic [4:0] vrf_rs1_o, vrf_rs2_o, vrf_rd_o;
  logic vrf_wr_req_o, vrf_wr_gnt_i;
  logic [31:0] vrf_wr_data_o;
  logic [3:0] vrf_wr_be_o;
  logic [31:0] ex_operand_a_o, ex_operand_b_o, ex_operand_c_o;
  logic ex_vec_instr_o, ex_first_cycle_o, ex_valid_i;
  logic [2:0] ex_vsew_o;
  logic [31:0] ex_result_i;
  logic [1:0] imd_val_we_i;
  logic [1:0][33:0] imd_val_d_i, imd_val_q_o;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] seed;

  always #5 clk_i = ~clk_i;

  vcve2_vec_ex_seq #(.VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .start_ready_o(start_ready_o),
    .flush_i(flush_i), .vl_i(vl_i), .vsew_i(vsew_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .vrf_rd_req_o(vrf_rd_req_o), .vrf_rd_gnt_i(vrf_rd_gnt_i), .vrf_rd_rvalid_i(vrf_rd_rvalid_i),
    .vrf_rdata_a_i(vrf_rdata_a_i), .vrf_rdata_b_i(vrf_rdata_b_i), .vrf_rdata_c_i(vrf_rdata_c_i),
    .vrf_word_o(vrf_word_o), .vrf_rs1_o(vrf_rs1_o), .vrf_rs2_o(vrf_rs2_o), .vrf_rd_o(vrf_rd_o),
    .vrf_wr_req_o(vrf_wr_req_o), .vrf_wr_gnt_i(vrf_wr_gnt_i), .vrf_wr_data_o(vrf_wr_data_o),
    .vrf_wr_be_o(vrf_wr_be_o), .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
    .ex_operand_c_o(ex_operand_c_o), .ex_vec_instr_o(ex_vec_instr_o), .ex_vsew_o(ex_vsew_o),
    .ex_first_cycle_o(ex_first_cycle_o), .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
    .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i), .imd_val_q_o(imd_val_q_o)
  );

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vrf_word(input logic [4:0] r, input int w);
    return (32'h9E3779B9 * (32'(r) * 32'd8 + 32'(w) + 32'd1)) ^ seed;
  endfunction

  function automatic logic [31:0] ex_fn(input logic [31:0] a, b, c);
    return (a + b) ^ {c[15:0], c[31:16]};
  endfunction

  function automatic int pick(input int fixed, input int mx);
    return (fixed >= 0) ? fixed : int'($urandom_range(0, mx));
  endfunction

  task automatic drive_idle();
    vrf_rd_gnt_i = 1'b0; vrf_rd_rvalid_i = 1'b0; ex_valid_i = 1'b0;
    vrf_wr_gnt_i = 1'b0; flush_i = 1'b0; imd_val_we_i = 2'b00;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", start_ready_o, 1);
    chk("rst_ctl", {busy_o, done_o, err_o, vrf_rd_req_o, vrf_wr_req_o, ex_vec_instr_o,
                    ex_first_cycle_o}, 0);
    chk("rst_regs", {vrf_word_o, vrf_rs1_o, vrf_rs2_o, vrf_rd_o, ex_vsew_o, vrf_wr_be_o}, 0);
    chk("rst_data", {vrf_wr_data_o, ex_operand_a_o}, 0);
    chk("rst_opbc", {ex_operand_b_o, ex_operand_c_o}, 0);
    chk("rst_imd", imd_val_q_o, 0);
  endtask

  // One op end to end; called and returning at a falling edge.
  task automatic run_op(input int vl, input int vsew, input int max_dly, input int ex_dly,
                        input int wr_dly, input int flush_at, input bit imd_mode,
                        output int done_cycle);
    int bytes, nwords, cyc, ndone, nrd;
    int rd_wait, rv_wait, ex_wait, wr_wait, ex_cnt, rv_word;
    bit rv_pend, finished, flushed;
    logic [4:0] r1, r2, r3;
    logic [31:0] exp_data[$];
    logic [3:0] exp_be[$];
    int exp_word[$];
    logic [1:0][33:0] imd_exp;
    r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
    seed = $urandom;
    bytes = vl << vsew;
    nwords = (bytes + 3) / 4;
    for (int w = 0; w < nwords; w++) begin
      exp_word.push_back(w);
      exp_be.push_back((w == nwords - 1 && bytes % 4 != 0) ? 4'((1 << (bytes % 4)) - 1) : 4'hF);
      exp_data.push_back(ex_fn(vrf_word(r1, w), vrf_word(r2, w), vrf_word(r3, w)));
    end
    done_cycle = -1; ndone = 0; nrd = 0; rv_pend = 0; finished = 0; flushed = 0;
    ex_cnt = 0; rv_word = 0; rv_wait = 0;
    rd_wait = pick(-1, max_dly); ex_wait = pick(ex_dly, max_dly); wr_wait = pick(wr_dly, max_dly);
    imd_exp = '0;
    chk("start_ready", start_ready_o, 1);
    drive_idle();
    vl_i = VLW'(vl); vsew_i = 3'(vsew); vs1_i = r1; vs2_i = r2; vd_i = r3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    vl_i = VLW'($urandom); vsew_i = 3'($urandom);
    vs1_i = 5'($urandom); vs2_i = 5'($urandom); vd_i = 5'($urandom);
    cyc = 1;
    while (!finished && cyc < 300) begin
      if (flushed) begin
        for (int k = 0; k < 4; k++) begin
          chk("flush_idle", {busy_o, done_o, vrf_rd_req_o, vrf_wr_req_o, ex_vec_instr_o}, 0);
          chk("flush_ready", start_ready_o, 1);
          drive_idle();
          if (rv_pend) begin
            vrf_rd_rvalid_i = 1'b1; rv_pend = 0;
            vrf_rdata_a_i = $urandom; vrf_rdata_b_i = $urandom; vrf_rdata_c_i = $urandom;
          end
          @(negedge clk_i);
        end
        finished = 1;
      end else begin
        if (imd_mode) chk("imd_q", imd_val_q_o, imd_exp);
        drive_idle();
        if (done_o) begin ndone++; done_cycle = cyc; finished = 1; end
        if (rv_pend) begin
          if (rv_wait == 0) begin
            vrf_rd_rvalid_i = 1'b1; rv_pend = 0;
            vrf_rdata_a_i = vrf_word(r1, rv_word);
            vrf_rdata_b_i = vrf_word(r2, rv_word);
            vrf_rdata_c_i = vrf_word(r3, rv_word);
          end else rv_wait--;
        end
        if (vrf_rd_req_o) begin
          chk("rd_in_range", nrd < nwords, 1);
          chk("rd_word", vrf_word_o, nrd);
          chk("rd_regs", {vrf_rs1_o, vrf_rs2_o, vrf_rd_o}, {r1, r2, r3});
          if (rd_wait == 0) begin
            vrf_rd_gnt_i = 1'b1; rv_pend = 1; rv_word = int'(vrf_word_o); nrd++;
            rv_wait = pick(-1, max_dly); rd_wait = pick(-1, max_dly);
          end else rd_wait--;
        end
        if (ex_vec_instr_o) begin
          chk("ex_first", ex_first_cycle_o, ex_cnt == 0);
          if (ex_cnt == 0) begin
            chk("op_a", ex_operand_a_o, vrf_word(r1, nrd - 1));
            chk("op_b", ex_operand_b_o, vrf_word(r2, nrd - 1));
            chk("op_c", ex_operand_c_o, vrf_word(r3, nrd - 1));
            chk("ex_vsew", ex_vsew_o, vsew);
          end
          if (ex_wait == 0) begin
            ex_valid_i = 1'b1;
            ex_result_i = ex_fn(ex_operand_a_o, ex_operand_b_o, ex_operand_c_o);
            ex_cnt = 0; ex_wait = pick(ex_dly, max_dly);
          end else begin
            ex_wait--; ex_cnt++;
          end
        end else chk("ex_first_off", ex_first_cycle_o, 0);
        if (vrf_wr_req_o) begin
          chk("wr_expected", exp_data.size() > 0, 1);
          if (exp_data.size() > 0) begin
            chk("wr_word", vrf_word_o, exp_word[0]);
            chk("wr_data", vrf_wr_data_o, exp_data[0]);
            chk("wr_be", vrf_wr_be_o, exp_be[0]);
            if (wr_wait == 0) begin
              vrf_wr_gnt_i = 1'b1;
              void'(exp_word.pop_front()); void'(exp_data.pop_front()); void'(exp_be.pop_front());
              wr_wait = pick(wr_dly, max_dly);
            end else wr_wait--;
          end
        end
        if (imd_mode) begin
          imd_val_we_i = ex_vec_instr_o ? 2'b11 : 2'($urandom);
          imd_val_d_i[0] = 34'({$urandom, $urandom});
          imd_val_d_i[1] = 34'({$urandom, $urandom});
          for (int i = 0; i < 2; i++) if (imd_val_we_i[i]) imd_exp[i] = imd_val_d_i[i];
        end
        if (cyc == flush_at && !done_o) begin flush_i = 1'b1; flushed = 1; end
        @(negedge clk_i);
        cyc++;
      end
    end
    drive_idle();
    chk("op_finished", finished, 1);
    chk("done_count", ndone, flushed ? 0 : 1);
    chk("done_single", done_o, 0);
    if (!flushed) chk("wr_left", exp_data.size(), 0);
  endtask

  int dc;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; vl_i = '0; vsew_i = '0; vs1_i = '0; vs2_i = '0; vd_i = '0;
    vrf_rdata_a_i = '0; vrf_rdata_b_i = '0; vrf_rdata_c_i = '0; ex_result_i = '0;
    imd_val_d_i = '0;
    drive_idle();
    repeat (2) @(negedge clk_i);
    chk_reset_vals();
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op(16, 0, 0, 0, 0, -1, 0, dc);
    chk("done_cycle_full", dc, 17);
    run_op(5, 1, 0, -1, -1, -1, 0, dc);
    chk("done_cycle_tail", dc, 13);
    run_op(0, 2, 0, -1, -1, -1, 0, dc);
    chk("done_cycle_vl0", dc, 1);

    for (int i = 0; i < 3; i++) begin
      vsew_i = (i == 0) ? 3'b011 : 3'(4 + $urandom_range(0, 3));
      vl_i = VLW'($urandom_range(1, 16));
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("err_pulse", err_o, 1);
      chk("err_no_op", {busy_o, vrf_rd_req_o, vrf_wr_req_o, done_o}, 0);
      @(negedge clk_i);
      chk("err_once", err_o, 0);
      chk("err_no_op2", {busy_o, vrf_rd_req_o, vrf_wr_req_o, done_o}, 0);
    end

    run_op(4, 2, 0, 3, 0, -1, 1, dc);
    chk("done_cycle_imd", dc, 29);
    run_op(4, 0, 0, 0, 5, -1, 0, dc);
    chk("done_cycle_wrhold", dc, 10);
    run_op(16, 0, 0, 0, 0, 3, 0, dc);
    run_op(8, 1, 0, 0, 5, 6, 0, dc);

    for (int i = 0; i < 16; i++) begin
      int vs, vl;
      vs = $urandom_range(0, 2);
      vl = $urandom_range(0, 16 >> vs);
      run_op(vl, vs, $urandom_range(0, 3), -1, -1, (i % 4 == 3) ? $urandom_range(1, 20) : -1,
             1'($urandom), dc);
    end

    vl_i = VLW'(8); vsew_i = 3'b000; vs1_i = 5'd3; vs2_i = 5'd4; vd_i = 5'd5; start_i = 1'b1;
    vrf_rd_gnt_i = 1'b1; vrf_rd_rvalid_i = 1'b1;
    vrf_rdata_a_i = $urandom | 32'h1; vrf_rdata_b_i = $urandom | 32'h1; vrf_rdata_c_i = $urandom | 32'h1;
    imd_val_we_i = 2'b11;
    imd_val_d_i[0] = 34'h1_2345_6789; imd_val_d_i[1] = 34'h2_8765_4321;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int t = 0; t < 20 && !ex_vec_instr_o; t++) @(negedge clk_i);
    chk("reach_exec", ex_vec_instr_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals();
    drive_idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op(12, 0, 2, -1, -1, -1, 1, dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
